// File: rtl/qupls_checkpoint_ctrl.sv
// Checkpoint allocator/retirer for the Q+ rename stage: hands out RAT checkpoints in order,
// retires them in order on branch commit and sequences restore plus stomp sweep on a miss.
module qupls_checkpoint_ctrl #(
  parameter int NCHECK    = 16,
  parameter int SWEEP_CYC = 4,
  localparam int CPW      = $clog2(NCHECK)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alloc_req,
  output logic           alloc_ack,
  output logic [CPW-1:0] alloc_cp,
  input  logic           cmt_br,
  input  logic [CPW-1:0] cmt_cp,
  input  logic           miss,
  input  logic [CPW-1:0] miss_cp,
  output logic [CPW-1:0] cndx_o,
  output logic [CPW-1:0] head_o,
  output logic [CPW:0]   nob_o,
  output logic           stall_o,
  output logic           restore_o,
  output logic [CPW-1:0] restore_cp_o,
  output logic           busy_o,
  output logic           err_o
);

  localparam int SCW = (SWEEP_CYC > 1) ? $clog2(SWEEP_CYC) : 1;
  localparam logic [SCW-1:0] SWEEP_LOAD = SCW'(SWEEP_CYC - 1);
  localparam logic [SCW-1:0] SCNT_ZERO  = SCW'(0);
  localparam logic [SCW-1:0] SCNT_ONE   = SCW'(1);
  localparam logic [CPW:0]   NOB_FULL   = (CPW+1)'(NCHECK - 1);
  localparam logic [CPW:0]   NOB_ZERO   = (CPW+1)'(0);
  localparam logic [CPW:0]   NOB_ONE    = (CPW+1)'(1);
  localparam logic [CPW-1:0] CP_ONE     = CPW'(1);
  localparam logic [CPW-1:0] CP_ZERO    = CPW'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_SWEEP   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [SCW-1:0]   sweep_cnt_r, sweep_cnt_s;
  logic [CPW-1:0]   cndx_r, cndx_s;
  logic [CPW-1:0]   head_r, head_s;
  logic [CPW:0]     nob_r, nob_s;
  logic [CPW-1:0]   restore_cp_r, restore_cp_s;
  logic             restore_r, busy_r, err_r, err_s;

  logic             stall_s;
  logic             cmt_ok_s, cmt_err_s;
  logic             miss_take_s, miss_err_s, miss_in_range_s;
  logic [CPW-1:0]   miss_age_s, rcp_age_s;

  // Distance of an index from the oldest live checkpoint, modulo NCHECK.
  function automatic logic [CPW-1:0] age_f(input logic [CPW-1:0] idx, input logic [CPW-1:0] head);
    return idx - head;
  endfunction

  assign stall_s   = busy_r | miss | (nob_r == NOB_FULL);
  assign alloc_ack = alloc_req & ~stall_s;
  assign alloc_cp  = cndx_r + CP_ONE;

  assign stall_o      = stall_s;
  assign cndx_o       = cndx_r;
  assign head_o       = head_r;
  assign nob_o        = nob_r;
  assign restore_o    = restore_r;
  assign restore_cp_o = restore_cp_r;
  assign busy_o       = busy_r;
  assign err_o        = err_r;

  // Commit and miss qualification against the live checkpoint window.
  always_comb begin
    cmt_ok_s        = cmt_br & (cmt_cp == head_r) & (nob_r != NOB_ZERO);
    cmt_err_s       = cmt_br & ~cmt_ok_s;
    miss_age_s      = age_f(miss_cp, head_r);
    rcp_age_s       = age_f(restore_cp_r, head_r);
    miss_in_range_s = ({1'b0, miss_age_s} <= nob_r);
    miss_take_s     = 1'b0;
    miss_err_s      = 1'b0;
    if (state_r == ST_IDLE) begin
      miss_take_s = miss & miss_in_range_s;
      miss_err_s  = miss & ~miss_in_range_s;
    end else begin
      // While restoring, only a strictly older miss supersedes the one in flight.
      miss_take_s = miss & (miss_age_s < rcp_age_s);
      miss_err_s  = 1'b0;
    end
  end

  // Restore/sweep sequencing: one RESTORE cycle, then SWEEP_CYC sweep cycles.
  always_comb begin
    state_s     = state_r;
    sweep_cnt_s = sweep_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_take_s) begin
          state_s = ST_RESTORE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RESTORE: begin
        if (miss_take_s) begin
          state_s = ST_RESTORE;
        end else begin
          state_s     = ST_SWEEP;
          sweep_cnt_s = SWEEP_LOAD;
        end
      end
      ST_SWEEP: begin
        if (miss_take_s) begin
          state_s = ST_RESTORE;
        end else if (sweep_cnt_r == SCNT_ZERO) begin
          state_s = ST_IDLE;
        end else begin
          sweep_cnt_s = sweep_cnt_r - SCNT_ONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        sweep_cnt_s = SCNT_ZERO;
      end
    endcase
  end

  // Checkpoint window update from alloc, commit and miss.
  always_comb begin
    cndx_s       = cndx_r;
    nob_s        = nob_r;
    head_s       = head_r;
    restore_cp_s = restore_cp_r;
    err_s        = err_r | cmt_err_s | miss_err_s;
    if (cmt_ok_s) begin
      head_s = head_r + CP_ONE;
    end else begin
      head_s = head_r;
    end
    if (miss_take_s) begin
      cndx_s       = miss_cp;
      restore_cp_s = miss_cp;
      // A commit of the restored head itself leaves an empty window.
      if (cmt_ok_s && (miss_age_s == CP_ZERO)) begin
        nob_s = NOB_ZERO;
      end else if (cmt_ok_s) begin
        nob_s = {1'b0, miss_age_s} - NOB_ONE;
      end else begin
        nob_s = {1'b0, miss_age_s};
      end
    end else begin
      if (alloc_ack) begin
        cndx_s = alloc_cp;
      end else begin
        cndx_s = cndx_r;
      end
      if (alloc_ack && !cmt_ok_s) begin
        nob_s = nob_r + NOB_ONE;
      end else if (!alloc_ack && cmt_ok_s) begin
        nob_s = nob_r - NOB_ONE;
      end else begin
        nob_s = nob_r;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sweep_cnt_r  <= SCNT_ZERO;
      cndx_r       <= CP_ZERO;
      head_r       <= CP_ZERO;
      nob_r        <= NOB_ZERO;
      restore_cp_r <= CP_ZERO;
      restore_r    <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      sweep_cnt_r  <= sweep_cnt_s;
      cndx_r       <= cndx_s;
      head_r       <= head_s;
      nob_r        <= nob_s;
      restore_cp_r <= restore_cp_s;
      restore_r    <= (state_s == ST_RESTORE);
      busy_r       <= (state_s != ST_IDLE);
      err_r        <= err_s;
    end
  end

endmodule
